// File: rtl/fetch_unit_if.sv
// Vector-fetch bus: datapath index in, BRAM address/data, packed vector and valid out.
interface fetch_unit_if #(
    parameter int matSize  = 16,
    parameter int memDepth = 12
);
    localparam int AW = $clog2(matSize*2-1);

    logic [AW-1:0]         readAddr;
    logic [31:0]           dataIn;
    logic [memDepth-1:0]   addrIn;
    logic [matSize*32-1:0] dataOut;
    logic                  valid;

    // fetch unit side: drives the BRAM address and the packed vector
    modport master (
        input  readAddr,
        input  dataIn,
        output addrIn,
        output dataOut,
        output valid
    );

    // environment side: datapath index and BRAM read data
    modport slave (
        output readAddr,
        output dataIn,
        input  addrIn,
        input  dataOut,
        input  valid
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: reads matSize sequential words from a 1-cycle-latency BRAM
// starting at readAddr*matSize and packs them into one wide register.
module fetch_unit #(
    parameter int matSize  = 16,
    parameter int memDepth = 12
) (
    input  logic         clk,
    input  logic         RESET,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(matSize*2-1);
    localparam int IW = (matSize > 1) ? $clog2(matSize) : 1;
    localparam logic [IW-1:0] LAST = IW'(matSize-1);

    typedef enum logic [1:0] {START, ADDR, CAPT, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [memDepth-1:0]   r_base;
    logic [memDepth-1:0]   w_base_n;
    logic [memDepth-1:0]   r_addr;
    logic [memDepth-1:0]   w_addr_n;
    logic [memDepth-1:0]   w_startBase;
    logic [AW-1:0]         r_vidx;
    logic [AW-1:0]         w_vidx_n;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_idx_n;
    logic                  r_valid;
    logic                  w_valid_n;
    logic                  w_capt;
    logic [matSize*32-1:0] r_data;

    // Product is taken modulo 2^memDepth; truncating the operand first is equivalent.
    assign w_startBase = memDepth'(bus.readAddr) * memDepth'(matSize);

    assign bus.addrIn  = r_addr;
    assign bus.dataOut = r_data;
    assign bus.valid   = r_valid;

    // State register
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) r_state <= START;
        else        r_state <= w_next;
    end

    // Next-state: two cycles per word, then wait in DONE until the index changes
    always_comb begin
        w_next = r_state;
        case (r_state)
            START:   w_next = ADDR;
            ADDR:    w_next = CAPT;
            CAPT:    w_next = (r_idx == LAST) ? DONE : ADDR;
            DONE:    w_next = (bus.readAddr != r_vidx) ? START : DONE;
            default: w_next = START;
        endcase
    end

    // Output/datapath control: next values of the registered outputs and counters
    always_comb begin
        w_base_n  = r_base;
        w_vidx_n  = r_vidx;
        w_idx_n   = r_idx;
        w_addr_n  = r_addr;
        w_valid_n = r_valid;
        w_capt    = 1'b0;
        case (r_state)
            START: begin
                w_base_n  = w_startBase;
                w_vidx_n  = bus.readAddr;
                w_addr_n  = w_startBase;
                w_idx_n   = '0;
                w_valid_n = 1'b0;
            end
            CAPT: begin
                w_capt = 1'b1;
                if (r_idx == LAST) begin
                    w_valid_n = 1'b1;
                end else begin
                    w_idx_n  = r_idx + IW'(1);
                    w_addr_n = r_base + memDepth'(r_idx) + memDepth'(1);
                end
            end
            DONE: begin
                if (bus.readAddr != r_vidx) w_valid_n = 1'b0;
            end
            default: ;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_base  <= '0;
            r_vidx  <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_base  <= w_base_n;
            r_vidx  <= w_vidx_n;
            r_idx   <= w_idx_n;
            r_addr  <= w_addr_n;
            r_valid <= w_valid_n;
        end
    end

    // Word capture: only the addressed slot changes, others keep prior contents
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET)      r_data <= '0;
        else if (w_capt) r_data[{r_idx, 5'b0} +: 32] <= bus.dataIn;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: BRAM model, cycle-count reference model, directed scenarios.
module tb_fetch_unit;
    localparam int M     = 16;
    localparam int DEPTH = 12;

    logic clk;
    logic RESET;
    logic noise;
    int   n_checks;
    int   n_err;

    logic [31:0] mem [0:4095];

    fetch_unit_if #(.matSize(M), .memDepth(DEPTH)) bus ();

    fetch_unit #(.matSize(M), .memDepth(DEPTH)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return bus.dataOut[32*k +: 32];
    endfunction

    // BRAM: address seen during a cycle is returned as data in the following cycle
    initial begin : bram
        logic [DEPTH-1:0] a;
        bus.dataIn = '0;
        forever begin
            @(negedge clk);
            a = bus.addrIn;
            @(posedge clk);
            #1;
            bus.dataIn = noise ? 32'($urandom) : mem[a];
        end
    end

    // Reference model: t counts cycles since the START cycle of the current fetch.
    // Address for word k shown in cycles 2k+1..2k+2; word k visible from cycle 2k+3;
    // valid from cycle 2M+1 until the cycle after the index changes.
    int               m_t;
    logic [DEPTH-1:0] m_base;
    logic [DEPTH-1:0] m_prev;
    logic [4:0]       m_vidx;
    logic [31:0]      m_old [M];

    initial begin : cmp
        logic [DEPTH-1:0] e_addr;
        logic             e_valid;
        logic [31:0]      ew;
        logic [31:0]      bgot;
        logic [31:0]      bexp;
        int               bad;
        int               step;
        m_t = 0; m_base = '0; m_prev = '0; m_vidx = '0;
        for (int k = 0; k < M; k++) m_old[k] = '0;
        forever begin
            @(negedge clk);
            if (!RESET) begin
                m_t = 0; m_base = '0; m_prev = '0; m_vidx = '0;
                for (int k = 0; k < M; k++) m_old[k] = '0;
            end
            if (m_t == 0) begin
                e_addr = m_prev;
            end else begin
                step = (m_t - 1) / 2;
                if (step > M - 1) step = M - 1;
                e_addr = DEPTH'(m_base + step);
            end
            e_valid = (m_t >= 2*M + 1);
            chk("cmp_addrIn", 32'(bus.addrIn), 32'(e_addr));
            chk("cmp_valid", 32'(bus.valid), 32'(e_valid));
            bad = -1; bgot = '0; bexp = '0;
            for (int k = 0; k < M; k++) begin
                ew = (m_t >= 2*k + 3) ? mem[DEPTH'(m_base + k)] : m_old[k];
                if (bus.dataOut[32*k +: 32] !== ew && bad < 0) begin
                    bad = k; bgot = bus.dataOut[32*k +: 32]; bexp = ew;
                end
            end
            n_checks++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL cmp_dataOut word %0d got=%h exp=%h t=%0d", bad, bgot, bexp, m_t);
            end
            if (RESET) begin
                if (m_t == 0) begin
                    m_base = DEPTH'(int'(bus.readAddr) * M);
                    m_vidx = bus.readAddr;
                    m_t    = 1;
                end else if (m_t < 2*M + 1) begin
                    m_t++;
                end else if (bus.readAddr != m_vidx) begin
                    for (int k = 0; k < M; k++) m_old[k] = mem[DEPTH'(m_base + k)];
                    m_prev = DEPTH'(m_base + M - 1);
                    m_t    = 0;
                end
            end
        end
    end

    task automatic wait_valid(input logic lvl, input string nm, output int cnt);
        logic found;
        found = 1'b0;
        cnt   = 0;
        while (!found && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus.valid === lvl) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_err++;
            $display("FAIL %s timeout got=%b exp=%b", nm, bus.valid, lvl);
        end
    endtask

    task automatic fetch(input logic [4:0] idx, input string nm);
        int c0;
        int lat;
        @(posedge clk);
        #1;
        bus.readAddr = idx;
        wait_valid(1'b0, nm, c0);
        chk({nm, "_drop"}, 32'(c0), 32'd1);
        wait_valid(1'b1, nm, lat);
        chk({nm, "_lat"}, 32'(lat), 32'(2*M + 1));
    endtask

    initial begin : main
        int lat;
        int c0;
        logic got;
        n_checks = 0;
        n_err    = 0;
        noise    = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 32'hC0DE0000 | 32'(a);
        for (int k = 0; k < M; k++) mem[12'h190 + k] = 32'hFFFFFFFF - 32'(k);
        RESET        = 1'b1;
        bus.readAddr = 5'd25;
        #1 RESET = 1'b0;

        // reset held
        repeat (3) @(posedge clk);
        #2;
        chk("rst_addrIn", 32'(bus.addrIn), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_dataOut_nonzero", 32'(|bus.dataOut), 32'h0);

        // first fetch of vector 25 from reset release
        @(posedge clk);
        #1 RESET = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) chk("addr_first", 32'(bus.addrIn), 32'h190);
            if (lat == 3) chk("addr_second", 32'(bus.addrIn), 32'h191);
            if (bus.valid) got = 1'b1;
        end
        chk("latency", 32'(lat), 32'd33);
        chk("v25_word0", word(0), 32'hFFFFFFFF);
        chk("v25_word15", word(15), 32'hFFFFFFF0);
        chk("v25_addr_last", 32'(bus.addrIn), 32'h19F);

        // DONE holds while dataIn toggles
        noise = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        noise = 1'b0;
        chk("hold_valid", 32'(bus.valid), 32'h1);
        chk("hold_word0", word(0), 32'hFFFFFFFF);
        chk("hold_addr", 32'(bus.addrIn), 32'h19F);

        // boundary: vector 0
        fetch(5'd0, "v0");
        chk("v0_word0", word(0), 32'hC0DE0000);
        chk("v0_word15", word(15), 32'hC0DE000F);

        // index change mid-fetch is ignored until DONE
        @(posedge clk);
        #1 bus.readAddr = 5'd25;
        repeat (10) @(posedge clk);
        #1 bus.readAddr = 5'd3;
        wait_valid(1'b1, "mid_first", lat);
        chk("mid_word0", word(0), 32'hFFFFFFFF);
        chk("mid_word15", word(15), 32'hFFFFFFF0);
        chk("mid_addr", 32'(bus.addrIn), 32'h19F);
        wait_valid(1'b0, "mid_drop", c0);
        chk("mid_drop_cnt", 32'(c0), 32'd1);
        wait_valid(1'b1, "mid_second", lat);
        chk("mid_relat", 32'(lat), 32'd33);
        chk("v3_word0", word(0), 32'hC0DE0030);
        chk("v3_word15", word(15), 32'hC0DE003F);

        // boundary: vector 31
        fetch(5'd31, "v31");
        chk("v31_word0", word(0), 32'hC0DE01F0);
        chk("v31_word15", word(15), 32'hC0DE01FF);
        chk("v31_addr", 32'(bus.addrIn), 32'h1FF);

        // asynchronous reset in the middle of a fetch
        @(posedge clk);
        #1 bus.readAddr = 5'd5;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #2 RESET = 1'b0;
        #1;
        chk("arst_addrIn", 32'(bus.addrIn), 32'h0);
        chk("arst_valid", 32'(bus.valid), 32'h0);
        chk("arst_dataOut_nonzero", 32'(|bus.dataOut), 32'h0);
        repeat (2) @(posedge clk);
        #1 RESET = 1'b1;
        wait_valid(1'b1, "v5", lat);
        chk("v5_lat", 32'(lat), 32'd33);
        chk("v5_word0", word(0), 32'hC0DE0050);
        chk("v5_word15", word(15), 32'hC0DE005F);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
